// File: rtl/rpn_token_decoder_if.sv
// Character-in / ALU-command-out bundle for the RPN token decoder.
// The decoder takes the slave side; the character source / ALU sees master.
interface rpn_token_decoder_if #(
  parameter int N = 16
);
  logic [7:0]   char_in;
  logic         char_valid;
  logic         char_ready;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data;
  logic         alu_valid;
  logic         expr_done;
  logic         num_overflow;
  logic         err_char;

  modport slave (
    input  char_in,
    input  char_valid,
    output char_ready,
    output alu_opcode,
    output alu_data,
    output alu_valid,
    output expr_done,
    output num_overflow,
    output err_char
  );

  modport master (
    output char_in,
    output char_valid,
    input  char_ready,
    input  alu_opcode,
    input  alu_data,
    input  alu_valid,
    input  expr_done,
    input  num_overflow,
    input  err_char
  );
endinterface

// File: rtl/rpn_token_decoder.sv
// ASCII postfix expression front end: decimal operands become pushes,
// '+', '*' and '=' become add, mul and pop commands for the stack ALU.
module rpn_token_decoder #(
  parameter int N = 16
) (
  input logic               clk,
  input logic               rst_n,
  rpn_token_decoder_if.slave bus
);

  localparam int AW = N + 4;

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD_OP
  } state_t;

  state_t       state, state_next;
  logic [N-1:0] acc, acc_next;
  logic [2:0]   held, held_next;

  logic [2:0]   opcode_next;
  logic [N-1:0] data_next;
  logic         valid_next;
  logic         done_next;
  logic         err_next;
  logic         ovf_next;
  logic         ready_next;

  logic         accept;
  logic         pending;
  logic         is_digit;
  logic         is_space;
  logic         is_add;
  logic         is_mul;
  logic         is_eq;
  logic [3:0]   digit;
  logic [AW-1:0] acc_mac;
  logic [2:0]   cmd;

  assign accept   = bus.char_valid && bus.char_ready;
  assign pending  = (state == ACC);
  assign is_digit = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
  assign is_space = (bus.char_in == 8'h20);
  assign is_add   = (bus.char_in == 8'h2B);
  assign is_mul   = (bus.char_in == 8'h2A);
  assign is_eq    = (bus.char_in == 8'h3D);
  assign digit    = bus.char_in[3:0];

  // Wide enough that acc*10+9 never wraps, so the top nibble flags overflow.
  assign acc_mac = (AW'(acc) * AW'(10)) + AW'(digit);

  always_comb begin
    cmd = OP_POP;
    unique case (1'b1)
      is_add:  cmd = OP_ADD;
      is_mul:  cmd = OP_MUL;
      default: cmd = OP_POP;
    endcase
  end

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    held_next   = held;
    opcode_next = OP_IDLE;
    data_next   = '0;
    valid_next  = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    ovf_next    = bus.num_overflow;

    unique case (state)
      HOLD_OP: begin
        opcode_next = held;
        valid_next  = 1'b1;
        done_next   = (held == OP_POP);
        held_next   = OP_IDLE;
        state_next  = IDLE;
      end
      IDLE, ACC: begin
        if (accept) begin
          unique case (1'b1)
            is_digit: begin
              acc_next   = acc_mac[N-1:0];
              state_next = ACC;
              if (|acc_mac[AW-1:N])
                ovf_next = 1'b1;
            end
            is_space: begin
              if (pending) begin
                opcode_next = OP_PUSH;
                data_next   = acc;
                valid_next  = 1'b1;
              end
              acc_next   = '0;
              state_next = IDLE;
            end
            is_add, is_mul, is_eq: begin
              valid_next = 1'b1;
              acc_next   = '0;
              if (pending) begin
                opcode_next = OP_PUSH;
                data_next   = acc;
                held_next   = cmd;
                state_next  = HOLD_OP;
              end else begin
                opcode_next = cmd;
                done_next   = (cmd == OP_POP);
                state_next  = IDLE;
              end
            end
            default: err_next = 1'b1;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase

    ready_next = (state_next != HOLD_OP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      acc              <= '0;
      held             <= OP_IDLE;
      bus.alu_opcode   <= OP_IDLE;
      bus.alu_data     <= '0;
      bus.alu_valid    <= 1'b0;
      bus.expr_done    <= 1'b0;
      bus.err_char     <= 1'b0;
      bus.num_overflow <= 1'b0;
      bus.char_ready   <= 1'b1;
    end else begin
      state            <= state_next;
      acc              <= acc_next;
      held             <= held_next;
      bus.alu_opcode   <= opcode_next;
      bus.alu_data     <= data_next;
      bus.alu_valid    <= valid_next;
      bus.expr_done    <= done_next;
      bus.err_char     <= err_next;
      bus.num_overflow <= ovf_next;
      bus.char_ready   <= ready_next;
    end
  end

endmodule

// File: tb/tb_rpn_token_decoder.sv
// Directed scenarios for rpn_token_decoder with a negedge command recorder.
// Each task drives its string and checks the recorded commands inline.
module tb_rpn_token_decoder;

  localparam int N = 16;

  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] data;
    logic         done;
  } cmd_t;

  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rpn_token_decoder_if #(.N(N)) bus ();

  rpn_token_decoder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  cmd_t q[$];
  int   stall_cnt = 0;
  int   err_cnt   = 0;
  int   idle_bad  = 0;

  always @(negedge clk) begin
    if (bus.alu_valid)
      q.push_back('{op: bus.alu_opcode, data: bus.alu_data, done: bus.expr_done});
    else if (bus.alu_opcode != 3'b000 || bus.alu_data != '0 || bus.expr_done)
      idle_bad++;
    if (bus.expr_done && bus.alu_opcode != POP)
      idle_bad++;
    if (!bus.char_ready)
      stall_cnt++;
    if (bus.err_char)
      err_cnt++;
  end

  function automatic cmd_t mk(input logic [2:0] op, input int d, input logic dn);
    mk.op   = op;
    mk.data = N'(d);
    mk.done = dn;
  endfunction

  task automatic clear_mon();
    q.delete();
    stall_cnt = 0;
    err_cnt   = 0;
  endtask

  task automatic send(input byte c);
    int n = 0;
    while (!bus.char_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.char_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: char_ready=%b required 1", bus.char_ready);
    end
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    @(negedge clk);
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send(s[i]);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.alu_opcode, bus.alu_data, bus.alu_valid, bus.expr_done,
         bus.num_overflow, bus.err_char, bus.char_ready} !== {3'b000, 16'h0, 5'b00001}) begin
      errors++;
      $display("FAIL reset_outputs: op=%b data=%h v=%b d=%b ovf=%b err=%b rdy=%b",
               bus.alu_opcode, bus.alu_data, bus.alu_valid, bus.expr_done,
               bus.num_overflow, bus.err_char, bus.char_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_expr();
    cmd_t exp[$];
    clear_mon();
    send_str("10 20+=");
    drain();
    exp = '{mk(PUSH, 10, 0), mk(PUSH, 20, 0), mk(ADD, 0, 0), mk(POP, 0, 1)};
    checks++;
    if (q.size() !== exp.size()) begin
      errors++;
      $display("FAIL add_count: got %0d cmds required %0d", q.size(), exp.size());
    end
    foreach (exp[i]) if (i < q.size()) begin
      checks++;
      if (q[i] !== exp[i]) begin
        errors++;
        $display("FAIL add_cmd%0d: got %h required %h", i, q[i], exp[i]);
      end
    end
    checks++;
    if (stall_cnt !== 1) begin
      errors++;
      $display("FAIL add_stalls: got %0d required 1", stall_cnt);
    end
  endtask

  task automatic test_mul_expr();
    cmd_t exp[$];
    clear_mon();
    send_str("3 4*=");
    drain();
    exp = '{mk(PUSH, 3, 0), mk(PUSH, 4, 0), mk(MUL, 0, 0), mk(POP, 0, 1)};
    checks++;
    if (q.size() !== exp.size()) begin
      errors++;
      $display("FAIL mul_count: got %0d cmds required %0d", q.size(), exp.size());
    end
    foreach (exp[i]) if (i < q.size()) begin
      checks++;
      if (q[i] !== exp[i]) begin
        errors++;
        $display("FAIL mul_cmd%0d: got %h required %h", i, q[i], exp[i]);
      end
    end
    checks++;
    if (bus.num_overflow !== 1'b0) begin
      errors++;
      $display("FAIL mul_ovf: got %b required 0", bus.num_overflow);
    end
  endtask

  task automatic test_max_operand();
    cmd_t exp[$];
    clear_mon();
    send_str("32767 1+=");
    drain();
    exp = '{mk(PUSH, 32767, 0), mk(PUSH, 1, 0), mk(ADD, 0, 0), mk(POP, 0, 1)};
    checks++;
    if (q.size() !== exp.size()) begin
      errors++;
      $display("FAIL max_count: got %0d cmds required %0d", q.size(), exp.size());
    end
    foreach (exp[i]) if (i < q.size()) begin
      checks++;
      if (q[i] !== exp[i]) begin
        errors++;
        $display("FAIL max_cmd%0d: got %h required %h", i, q[i], exp[i]);
      end
    end
    checks++;
    if (bus.num_overflow !== 1'b0) begin
      errors++;
      $display("FAIL max_ovf: got %b required 0", bus.num_overflow);
    end
  endtask

  task automatic test_unpending_ops();
    cmd_t exp[$];
    clear_mon();
    send_str("5 6 + =");
    drain();
    exp = '{mk(PUSH, 5, 0), mk(PUSH, 6, 0), mk(ADD, 0, 0), mk(POP, 0, 1)};
    checks++;
    if (q.size() !== exp.size()) begin
      errors++;
      $display("FAIL nopend_count: got %0d cmds required %0d", q.size(), exp.size());
    end
    foreach (exp[i]) if (i < q.size()) begin
      checks++;
      if (q[i] !== exp[i]) begin
        errors++;
        $display("FAIL nopend_cmd%0d: got %h required %h", i, q[i], exp[i]);
      end
    end
    checks++;
    if (stall_cnt !== 0) begin
      errors++;
      $display("FAIL nopend_stalls: got %0d required 0", stall_cnt);
    end
  endtask

  task automatic test_overflow();
    cmd_t exp[$];
    clear_mon();
    send_str("70000 ");
    drain();
    checks++;
    if (bus.num_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b required 1", bus.num_overflow);
    end
    send_str("=");
    drain();
    exp = '{mk(PUSH, 16'h1170, 0), mk(POP, 0, 1)};
    checks++;
    if (q.size() !== exp.size()) begin
      errors++;
      $display("FAIL ovf_count: got %0d cmds required %0d", q.size(), exp.size());
    end
    foreach (exp[i]) if (i < q.size()) begin
      checks++;
      if (q[i] !== exp[i]) begin
        errors++;
        $display("FAIL ovf_cmd%0d: got %h required %h", i, q[i], exp[i]);
      end
    end
    checks++;
    if (bus.num_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required 1", bus.num_overflow);
    end
  endtask

  task automatic test_bad_char();
    cmd_t exp[$];
    clear_mon();
    send_str("1x");
    checks++;
    if (bus.err_char !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: got %b required 1", bus.err_char);
    end
    send_str("2 ");
    drain();
    checks++;
    if (err_cnt !== 1) begin
      errors++;
      $display("FAIL err_width: got %0d cycles required 1", err_cnt);
    end
    exp = '{mk(PUSH, 12, 0)};
    checks++;
    if (q.size() !== exp.size()) begin
      errors++;
      $display("FAIL err_count: got %0d cmds required %0d", q.size(), exp.size());
    end
    foreach (exp[i]) if (i < q.size()) begin
      checks++;
      if (q[i] !== exp[i]) begin
        errors++;
        $display("FAIL err_cmd%0d: got %h required %h", i, q[i], exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    cmd_t exp[$];
    send_str("12");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.alu_opcode, bus.alu_data, bus.alu_valid, bus.expr_done,
         bus.num_overflow, bus.err_char, bus.char_ready} !== {3'b000, 16'h0, 5'b00001}) begin
      errors++;
      $display("FAIL midrst_outputs: op=%b data=%h v=%b d=%b ovf=%b err=%b rdy=%b",
               bus.alu_opcode, bus.alu_data, bus.alu_valid, bus.expr_done,
               bus.num_overflow, bus.err_char, bus.char_ready);
    end
    rst_n = 1'b1;
    clear_mon();
    @(negedge clk);
    send_str(" ");
    drain();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL midrst_space: got %0d cmds required 0", q.size());
    end
    send_str("5=");
    drain();
    exp = '{mk(PUSH, 5, 0), mk(POP, 0, 1)};
    checks++;
    if (q.size() !== exp.size()) begin
      errors++;
      $display("FAIL midrst_count: got %0d cmds required %0d", q.size(), exp.size());
    end
    foreach (exp[i]) if (i < q.size()) begin
      checks++;
      if (q[i] !== exp[i]) begin
        errors++;
        $display("FAIL midrst_cmd%0d: got %h required %h", i, q[i], exp[i]);
      end
    end
  endtask

  task automatic test_idle_values();
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("FAIL idle_values: got %0d bad cycles required 0", idle_bad);
    end
  endtask

  initial begin
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_expr();
    test_mul_expr();
    test_max_operand();
    test_unpending_ops();
    test_overflow();
    test_bad_char();
    test_mid_reset();
    test_idle_values();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
